shared_reg_arbiter: RTL and testbench
=====================================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 8: data width of the shared register.
- NREQ, 4: number of requesters, legal range 2..8.
- MAX_HOLD, 4: maximum consecutive locked writes per grant, legal range 1..15.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- req_valid, in, NREQ: per-requester write request.
- req_lock, in, NREQ: per-requester request to keep ownership after the current write.
- req_data, in, NREQ*WIDTH: packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready, out, NREQ: per-requester write accept.
- q, out, WIDTH: shared register contents.
- q_upd, out, 1: one-cycle pulse, high in the cycle after q changes.
- owner, out, clog2(NREQ): index of the current or most recent grantee.
- busy, out, 1: high while in state OWNED.
- wr_count, out, 16: total accepted writes; wraps modulo 2^16.

REQ-003 clk and reset_n SHALL be the only clock and reset; reset is asynchronous and active-low.

Function
REQ-004 The block SHALL implement a two-state FSM:
- IDLE: no owner.
- OWNED: one requester holds the register.

REQ-005 In IDLE, if any req_valid bit is set, the block SHALL select the first set bit searching upward from ptr with wrap-around, register it into owner, clear hold_cnt, and enter OWNED at the next edge.

REQ-006 In IDLE, req_ready SHALL be all zeros and no write SHALL occur.

REQ-007 In OWNED, req_ready[owner] SHALL equal 1 and all other req_ready bits SHALL be 0; req_ready is a pure function of registered state.

REQ-008 A handshake SHALL be req_valid[owner] & req_ready[owner] in OWNED. On a handshake the block SHALL, at the next edge:
- load q with the owner's req_data slice;
- increment wr_count;
- increment hold_cnt.

REQ-009 q_upd SHALL be a registered pulse, high exactly one cycle after each handshake cycle, coincident with the new q value.

REQ-010 After a handshake, the block SHALL remain in OWNED only if req_lock[owner] = 1 and hold_cnt+1 < MAX_HOLD; otherwise it SHALL enter IDLE and set ptr = (owner+1) mod NREQ.

REQ-011 In OWNED with req_valid[owner] = 0, the block SHALL enter IDLE at the next edge with no write and set ptr = (owner+1) mod NREQ.

REQ-012 Latency SHALL be as follows: request seen in IDLE at cycle t, req_ready high at t+1, q and q_upd updated at t+2 when valid is held.

REQ-013 A locked owner SHALL sustain one write per cycle, up to MAX_HOLD writes per grant.

REQ-014 Requests from non-owners during OWNED SHALL be ignored without side effects and SHALL be arbitrated at the next IDLE cycle.

REQ-015 Minimum turnaround between two grants SHALL be one IDLE cycle, giving round-robin fairness: each of N continuously requesting requesters receives a grant within N grants.

REQ-016 owner SHALL hold its last value while IDLE; busy SHALL equal (state == OWNED).

REQ-017 req_lock changes SHALL be sampled only on handshake cycles.

REQ-018 wr_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.

Reset
REQ-019 While reset_n = 0, the block SHALL asynchronously force:
- state = IDLE, ptr = 0, hold_cnt = 0;
- q = 0, q_upd = 0, owner = 0, busy = 0, wr_count = 0;
- req_ready = 0.

REQ-020 Reset asserted mid-ownership SHALL abort the grant with no write; a handshake in the same cycle as reset assertion SHALL be lost.

REQ-021 After reset_n deasserts, the first arbitration SHALL occur on the first rising edge at which reset_n is high.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single requester: req_valid = 4'b0100, data 8'hA5, lock 0 -> req_ready[2] at t+1; q = 8'hA5 and q_upd = 1 at t+2; owner = 2; wr_count = 1; busy low at t+2.
- Full contention: req_valid = 4'b1111 held, lock 0, from reset -> grants in order 0,1,2,3,0; each write separated by one IDLE cycle; wr_count = 5 after five writes.
- Lock limit: MAX_HOLD = 4, requester 1 with lock = 1 and valid held for 10 cycles -> exactly 4 consecutive q_upd pulses, then IDLE; requester 3 (also valid) granted next.
- Withdrawal: requester 0 granted, req_valid[0] dropped in the first OWNED cycle -> no write, q unchanged, IDLE next, ptr = 1.
- Reset mid-operation: reset_n pulled low during a locked handshake -> q = 0, wr_count = 0, req_ready = 0 immediately; no q_upd after release.
- Wrap: wr_count preloaded via 65535 writes, one more write -> wr_count = 0 and q updated normally.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Shared register written by NREQ requesters through a round-robin arbiter.
// Owners may lock the register for up to MAX_HOLD back-to-back writes.
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [WIDTH-1:0]         q,
    output logic                     q_upd,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [15:0]              wr_count
);
    localparam int OWL = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t           r_state;
    logic [OWL-1:0]   r_ptr;
    logic [OWL-1:0]   r_owner;
    logic [3:0]       r_hold_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_q_upd;
    logic             r_busy;
    logic [15:0]      r_wr_count;
    logic [NREQ-1:0]  r_ready;

    logic [OWL-1:0]   w_pick;
    logic [NREQ-1:0]  w_pick_oh;
    logic             w_hs;
    logic             w_keep;
    logic [OWL-1:0]   w_next_ptr;
    logic [WIDTH-1:0] w_wdata;

    // First set request bit at or above p, wrapping past NREQ-1.
    function automatic logic [OWL-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [OWL-1:0] p);
        logic [OWL-1:0] pick;
        logic           found;
        int             idx;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(p) + k) % NREQ;
            if (!found && v[idx]) begin
                found = 1'b1;
                pick  = idx[OWL-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [OWL-1:0] ptr_inc(input logic [OWL-1:0] o);
        logic [OWL-1:0] n;
        if (int'(o) == NREQ - 1) begin
            n = '0;
        end else begin
            n = o + OWL'(1);
        end
        return n;
    endfunction

    // Arbitration pick, handshake detection and owner write data.
    always_comb begin
        w_pick     = rr_pick(req_valid, r_ptr);
        w_pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
        w_hs       = (r_state == ST_OWNED) && req_valid[r_owner] && r_ready[r_owner];
        w_keep     = req_lock[r_owner] && ((int'(r_hold_cnt) + 1) < MAX_HOLD);
        w_next_ptr = ptr_inc(r_owner);
        w_wdata    = req_data[int'(r_owner)*WIDTH +: WIDTH];
    end

    // Ownership FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_hold_cnt <= 4'd0;
            r_q        <= '0;
            r_q_upd    <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_count <= 16'd0;
            r_ready    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_q_upd <= 1'b0;
                    if (|req_valid) begin
                        r_owner    <= w_pick;
                        r_hold_cnt <= 4'd0;
                        r_ready    <= w_pick_oh;
                        r_busy     <= 1'b1;
                        r_state    <= ST_OWNED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_OWNED: begin
                    if (w_hs) begin
                        r_q        <= w_wdata;
                        r_q_upd    <= 1'b1;
                        r_wr_count <= r_wr_count + 16'd1;
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                        if (w_keep) begin
                            r_state <= ST_OWNED;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ptr   <= w_next_ptr;
                            r_ready <= '0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        // Owner withdrew: release without writing.
                        r_q_upd <= 1'b0;
                        r_state <= ST_IDLE;
                        r_ptr   <= w_next_ptr;
                        r_ready <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_q_upd <= 1'b0;
                    r_ready <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign q         = r_q;
    assign q_upd     = r_q_upd;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: directed scenarios on a default
// instance plus a 2-requester instance run concurrently for wr_count wrap.
module tb_shared_reg_arbiter;
    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  q;
    logic        q_upd;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] wr_count;

    logic        w_rst_n;
    logic [1:0]  w_valid;
    logic [1:0]  w_lock;
    logic [7:0]  w_data;
    logic [1:0]  w_ready;
    logic [7:0]  wq;
    logic        wq_upd;
    logic        w_owner;
    logic        w_busy;
    logic [15:0] wwr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [25:0] sb_q[$];
    logic [25:0] exp_e;
    logic [15:0] exp_wr;
    int          w_n      = 0;
    logic        w_done   = 1'b0;
    logic [7:0]  w_exp_q;

    shared_reg_arbiter #(.WIDTH(8), .NREQ(4), .MAX_HOLD(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_lock(req_lock),
        .req_data(req_data), .req_ready(req_ready), .q(q), .q_upd(q_upd),
        .owner(owner), .busy(busy), .wr_count(wr_count)
    );

    shared_reg_arbiter #(.WIDTH(8), .NREQ(2), .MAX_HOLD(15)) u_wrap (
        .clk(clk), .reset_n(w_rst_n), .req_valid(w_valid), .req_lock(w_lock),
        .req_data({8'h00, w_data}), .req_ready(w_ready), .q(wq), .q_upd(wq_upd),
        .owner(w_owner), .busy(w_busy), .wr_count(wwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] d, input logic [1:0] o);
        exp_wr = exp_wr + 16'd1;
        sb_q.push_back({d, o, exp_wr});
    endtask

    // Scoreboard monitor: every q_upd pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (q_upd === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: q=%0h owner=%0d wr_count=%0d, nothing expected", q, owner, wr_count);
            end else begin
                exp_e = sb_q.pop_front();
                chk("sb_write{q,owner,wr_count}", {6'b0, q, owner, wr_count}, {6'b0, exp_e});
            end
        end
    end

    // Wrap monitor: count pulses and check value at first write and around the wrap.
    always @(negedge clk) begin
        if (wq_upd === 1'b1) begin
            w_n++;
            if (w_n == 1 || w_n == 65535 || w_n == 65536) begin
                w_exp_q = w_data - 8'd1;
                chk("wrap_q", {24'b0, wq}, {24'b0, w_exp_q});
                chk("wrap_wr_count", {16'b0, wwr}, {16'b0, w_n[15:0]});
            end
            if (w_n == 65536) w_done = 1'b1;
        end
    end

    // Wrap instance stimulus: requester 0 locked and always valid, data ramps every cycle.
    initial begin
        w_rst_n = 1'b0;
        w_valid = 2'b01;
        w_lock  = 2'b01;
        w_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 w_rst_n = 1'b1;
        forever begin
            @(posedge clk);
            #1 w_data = w_data + 8'd1;
        end
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        req_data  = 32'h0;
        exp_wr    = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", {24'b0, q}, 32'h0);
        chk("rst_q_upd", {31'b0, q_upd}, 32'h0);
        chk("rst_owner", {30'b0, owner}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_wr_count", {16'b0, wr_count}, 32'h0);
        chk("rst_ready", {28'b0, req_ready}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Single requester 2.
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        tick();
        chk("single_ready_t1", {28'b0, req_ready}, 32'h4);
        chk("single_busy_t1", {31'b0, busy}, 32'h1);
        chk("single_owner", {30'b0, owner}, 32'h2);
        push_wr(8'hA5, 2'd2);
        tick();
        chk("single_q_upd_t2", {31'b0, q_upd}, 32'h1);
        chk("single_busy_t2", {31'b0, busy}, 32'h0);
        chk("single_ready_t2", {28'b0, req_ready}, 32'h0);
        req_valid = 4'b0000;
        tick();
        tick();

        // Full contention from reset.
        reset_n = 1'b0;
        #1;
        chk("rst_async_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_async_q", {24'b0, q}, 32'h0);
        exp_wr = 16'd0;
        tick();
        req_data  = 32'h44332211;
        req_valid = 4'b1111;
        reset_n   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] oh;
            logic [1:0] o;
            o  = 2'(i % 4);
            oh = 4'b0001 << o;
            tick();
            chk("rr_ready", {28'b0, req_ready}, {28'b0, oh});
            push_wr(8'h11 * 8'(o + 2'd1), o);
            tick();
            chk("rr_idle_after_write", {31'b0, busy}, 32'h0);
        end
        req_valid = 4'b0000;

        // Lock limit: requester 1 locked, requester 3 waiting.
        req_data[15:8]  = 8'h5C;
        req_data[31:24] = 8'hE3;
        req_valid = 4'b1010;
        req_lock  = 4'b0010;
        tick();
        chk("lock_ready", {28'b0, req_ready}, 32'h2);
        for (int k = 0; k < 4; k++) begin
            push_wr(8'h5C, 2'd1);
            tick();
            chk("lock_q_upd", {31'b0, q_upd}, 32'h1);
            chk("lock_busy", {31'b0, busy}, (k < 3) ? 32'h1 : 32'h0);
        end
        tick();
        chk("lock_next_ready", {28'b0, req_ready}, 32'h8);
        chk("lock_no_5th_pulse", {31'b0, q_upd}, 32'h0);
        push_wr(8'hE3, 2'd3);
        tick();
        chk("lock_r3_busy", {31'b0, busy}, 32'h0);
        req_valid = 4'b0010;
        tick();
        chk("lock_regrant_ready", {28'b0, req_ready}, 32'h2);
        push_wr(8'h5C, 2'd1);
        tick();
        push_wr(8'h5C, 2'd1);
        tick();
        chk("lock_still_owned", {31'b0, busy}, 32'h1);
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        tick();
        chk("lock_release_busy", {31'b0, busy}, 32'h0);

        // Withdrawal by requester 0 in its first owned cycle.
        req_data[7:0] = 8'h77;
        req_valid = 4'b0001;
        tick();
        chk("wd_ready", {28'b0, req_ready}, 32'h1);
        req_valid = 4'b0000;
        tick();
        chk("wd_busy", {31'b0, busy}, 32'h0);
        chk("wd_q_kept", {24'b0, q}, 32'h5C);
        req_data[15:8] = 8'h66;
        req_valid = 4'b1011;
        tick();
        chk("wd_ptr_is_1", {30'b0, owner}, 32'h1);
        req_valid = 4'b0000;
        tick();
        chk("wd2_q_kept", {24'b0, q}, 32'h5C);

        // Reset during a locked handshake.
        req_data[23:16] = 8'h9E;
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        tick();
        chk("mid_ready", {28'b0, req_ready}, 32'h4);
        push_wr(8'h9E, 2'd2);
        tick();
        chk("mid_busy", {31'b0, busy}, 32'h1);
        #6;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_q", {24'b0, q}, 32'h0);
        chk("mid_rst_wr_count", {16'b0, wr_count}, 32'h0);
        chk("mid_rst_ready", {28'b0, req_ready}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        exp_wr    = 16'd0;
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_q", {24'b0, q}, 32'h0);
        chk("post_rst_wr_count", {16'b0, wr_count}, 32'h0);
        chk("sb_drained", sb_q.size(), 32'h0);

        for (int c = 0; c < 80000 && !w_done; c++) @(posedge clk);
        if (!w_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d writes expected 65536", w_n);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
